// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int SUB_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int sub_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : 1-bit combinational full-subtractor cell (x - y - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor (a - b - bin), LSB first, one
//                full-subtractor cell and a registered borrow.
//                Optional macro SERIAL_SUBTRACTOR_OVF_EN enables signed ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = SUB_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int            CW     = sub_cnt_width(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    sub_state_t    r_state;
    sub_state_t    w_next;
    logic [N-1:0]  r_ra;
    logic [N-1:0]  r_rb;
    logic          r_borrow;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_diff;
    logic          r_bout;
    logic          w_load;
    logic          w_last;
    logic          w_d;
    logic          w_bo;

    full_subtractor u_cell (
        .x    (r_ra[0]),
        .y    (r_rb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bo)
    );

    // The edge leaving DONE is also an acceptance edge, giving one
    // operation every N+1 cycles when start is held high.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == C_LAST) begin
                    w_next = DONE;
                    w_last = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Result bits are shifted into the vacated MSB end of r_ra, so no
    // separate accumulator is needed; diff is copied only on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ra     <= '0;
            r_rb     <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= w_last;
            if (w_load) begin
                r_ra     <= a;
                r_rb     <= b;
                r_borrow <= bin;
                r_cnt    <= '0;
            end else if (r_state == SHIFT) begin
                r_ra     <= {w_d, r_ra[N-1:1]};
                r_rb     <= {1'b0, r_rb[N-1:1]};
                r_borrow <= w_bo;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_diff <= {w_d, r_ra[N-1:1]};
                r_bout <= w_bo;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load) begin
                r_amsb <= a[N-1];
                r_bmsb <= b[N-1];
            end
            if (w_last) begin
                r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor (N=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int checks;
    int errors;

    serial_subtractor #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] vec_a(input int k);
        return 8'(8'h3C + k * 17);
    endfunction

    function automatic logic [7:0] vec_b(input int k);
        return 8'(k * 29);
    endfunction

    function automatic logic vec_bin(input int k);
        return k[0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand ports may change freely while busy.
        a   = ~ta;
        b   = ~tb_v;
        bin = ~tbin;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_accept got %b want 1", nm, busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_at_accept got %b want 0", nm, done); end
        lat = 0;
        while (lat < 20 && done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL %s latency got %0d want 8", nm, lat); end
        checks++; if (diff !== ed) begin errors++; $display("FAIL %s diff got %h want %h", nm, diff, ed); end
        checks++; if (bout !== eb) begin errors++; $display("FAIL %s bout got %b want %b", nm, bout, eb); end
        checks++; if (ovf !== (eo & OVF_ON)) begin errors++; $display("FAIL %s ovf got %b want %b", nm, ovf, eo & OVF_ON); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", nm, done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", nm, busy); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (diff !== ed) begin errors++; $display("FAIL %s diff_hold got %h want %h", nm, diff, ed); end
    endtask

    task automatic test_arith();
        do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "sub_35_12");
        do_op(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, "sub_12_35");
        do_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_10_10_bin");
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "sub_zero");
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "sub_7f_ff");
    endtask

    task automatic test_back_to_back();
        logic       exp_done;
        logic [8:0] r9;
        int         src;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            start = 1'b1;
            a     = vec_a(k);
            b     = vec_b(k);
            bin   = vec_bin(k);
            @(posedge clk); #1;
            exp_done = (k == 8) || (k == 17) || (k == 26);
            checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, exp_done); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got %b want 1", k, busy); end
            if (exp_done) begin
                src = k - 8;
                r9  = {1'b0, vec_a(src)} - {1'b0, vec_b(src)} - {8'h00, vec_bin(src)};
                checks++; if (diff !== r9[7:0]) begin errors++; $display("FAIL b2b_diff k=%0d got %h want %h", k, diff, r9[7:0]); end
                checks++; if (bout !== r9[8]) begin errors++; $display("FAIL b2b_bout k=%0d got %b want %b", k, bout, r9[8]); end
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_end_done got %b want 0", done); end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        a     = 8'hA5;
        b     = 8'h11;
        bin   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL midrst_diff got %h want 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_idle i=%0d busy=%b done=%b want 0 0", i, busy, done); end
        end
        do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
